cpu_phase_sequencer: RTL and testbench

- Parametrised replacement for the CPU top-level free-running phase counter and derived cpu_clk.
- Runs on the single system clock and issues per-phase enables: fetch, memory, register write-back, PC update.
- Adds three things the fixed counter lacks: memory wait-state handshake, halt/single-step control, and a retired-instruction counter.
- Sits between the clock/reset pins and the PC, instruction fetch, decoder and data-memory blocks.

---
 rtl/cpu_phase_sequencer_pkg.sv | 29 ++
 rtl/cpu_phase_sequencer_retire_counter.sv | 19 +
 rtl/cpu_phase_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the CPU phase sequencer: state encoding, default
// phase constants and a constant-evaluable clog2.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_PHASES  = 8;
    localparam int DEF_MEM_PHASE   = 4;
    localparam int DEF_WB_PHASE    = 6;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_retire_counter.sv
// Retired-instruction counter: increments on each enable, wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Per-phase enable sequencer with memory wait states, halt/single-step and
// retire counting. Optional macro SEQ_MEM_TIMEOUT_EN bounds WAIT with a timeout.
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int NUM_PHASES   = DEF_NUM_PHASES,
    parameter int MEM_PHASE    = DEF_MEM_PHASE,
    parameter int WB_PHASE     = DEF_WB_PHASE,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int START_HALTED = 0,
`ifdef SEQ_MEM_TIMEOUT_EN
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
`endif
    localparam int PH_W        = clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             step,
    input  logic             mem_active,
    input  logic             mem_ready,
    output logic [PH_W-1:0]  phase,
    output logic             fetch_en,
    output logic             mem_req,
    output logic             reg_wr_en,
    output logic             pc_en,
    output logic             halted,
`ifdef SEQ_MEM_TIMEOUT_EN
    output logic             mem_timeout,
`endif
    output logic [CNT_W-1:0] instret
);

    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W-1:0] MEM_PH   = PH_W'(MEM_PHASE);
    localparam logic [PH_W-1:0] MEM_NEXT = PH_W'(MEM_PHASE + 1);
    localparam logic [PH_W-1:0] WB_PH    = PH_W'(WB_PHASE);

    seq_state_t state;
    logic       step_pend;
    logic       timeout_hit;
    logic       timeout_lock;
    logic       run;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int            TO_W    = clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt;

    assign timeout_hit  = (state == WAIT) && !mem_ready && (wait_cnt == TO_LAST);
    assign timeout_lock = mem_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == WAIT && !mem_ready) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_lock = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (START_HALTED != 0) ? HALT : RUN;
            phase     <= '0;
            step_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (phase == LAST_PH) begin
                        phase <= '0;
                        if (halt_req || step_pend) begin
                            state     <= HALT;
                            step_pend <= 1'b0;
                        end
                    end else if (phase == MEM_PH && mem_active && !mem_ready) begin
                        state <= WAIT;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                        phase <= MEM_NEXT;
                    end else if (timeout_hit) begin
                        state     <= HALT;
                        phase     <= '0;
                        step_pend <= 1'b0;
                    end
                end
                HALT: begin
                    phase <= '0;
                    // step takes priority over a held halt_req and over a timeout lock
                    if (step) begin
                        state     <= RUN;
                        step_pend <= 1'b1;
                    end else if (!halt_req && !timeout_lock) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= HALT;
                    phase <= '0;
                end
            endcase
        end
    end

    // Gated by rst so enables drop the instant reset asserts.
    assign run       = (state == RUN) && !rst;
    assign fetch_en  = run && (phase == '0);
    assign reg_wr_en = run && (phase == WB_PH);
    assign pc_en     = run && (phase == LAST_PH);
    assign mem_req   = (state == RUN || state == WAIT) && !rst && (phase == MEM_PH) && mem_active;
    assign halted    = (state == HALT);

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clk  (clk),
        .rst  (rst),
        .en   (pc_en),
        .count(instret)
    );

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer (default phases 8/4/6, CNT_W 32).
module tb_cpu_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_req = 1'b0;
    logic        step = 1'b0;
    logic        mem_active = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  phase;
    logic        fetch_en, mem_req, reg_wr_en, pc_en, halted;
    logic [31:0] instret;
`ifdef SEQ_MEM_TIMEOUT_EN
    logic        mem_timeout;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0]  phase;
        logic        fetch_en;
        logic        mem_req;
        logic        reg_wr_en;
        logic        pc_en;
        logic        halted;
        logic [31:0] instret;
    } obs_t;

    obs_t exp_q[$];

    cpu_phase_sequencer #(
        .NUM_PHASES  (8),
        .MEM_PHASE   (4),
        .WB_PHASE    (6),
        .CNT_W       (32),
`ifdef SEQ_MEM_TIMEOUT_EN
        .TIMEOUT_CYC (10),
`endif
        .START_HALTED(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .halt_req   (halt_req),
        .step       (step),
        .mem_active (mem_active),
        .mem_ready  (mem_ready),
        .phase      (phase),
        .fetch_en   (fetch_en),
        .mem_req    (mem_req),
        .reg_wr_en  (reg_wr_en),
        .pc_en      (pc_en),
        .halted     (halted),
`ifdef SEQ_MEM_TIMEOUT_EN
        .mem_timeout(mem_timeout),
`endif
        .instret    (instret)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.phase     = phase;
        o.fetch_en  = fetch_en;
        o.mem_req   = mem_req;
        o.reg_wr_en = reg_wr_en;
        o.pc_en     = pc_en;
        o.halted    = halted;
        o.instret   = instret;
        return o;
    endfunction

    // Expected observation for a given phase; decode enables are zero when halted.
    function automatic obs_t mk(input int ph, input bit h, input bit mreq, input int ir);
        obs_t o;
        o.phase     = 3'(ph);
        o.fetch_en  = !h && (ph == 0);
        o.mem_req   = mreq;
        o.reg_wr_en = !h && (ph == 6);
        o.pc_en     = !h && (ph == 7);
        o.halted    = h;
        o.instret   = 32'(ir);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ph=%0d fe=%b mr=%b rw=%b pc=%b h=%b ir=%0d",
                         o.phase, o.fetch_en, o.mem_req, o.reg_wr_en, o.pc_en, o.halted, o.instret);
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        halt_req   = 1'b0;
        step       = 1'b0;
        mem_active = 1'b0;
        mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back('0);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_hold c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(mk(c, 1'b0, 1'b0, 0));
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_release c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_free_run();
        obs_t got, want;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            exp_q.push_back(mk(c % 8, 1'b0, 1'b0, c / 8));
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL free_run c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        obs_t got, want;
        int ph, ir;
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            mem_active = 1'b1;
            mem_ready  = (c >= 9);
            if (c < 4)        ph = c;
            else if (c <= 9)  ph = 4;
            else if (c <= 12) ph = c - 5;
            else              ph = (c - 13) % 8;
            ir = (c >= 21) ? 2 : (c >= 13) ? 1 : 0;
            exp_q.push_back(mk(ph, 1'b0, ph == 4, ir));
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mem_wait c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        obs_t got, want;
        do_reset();
        for (int c = 0; c <= 29; c++) begin
            halt_req = (c >= 2 && c <= 27);
            if (c <= 7)       exp_q.push_back(mk(c, 1'b0, 1'b0, 0));
            else if (c <= 28) exp_q.push_back(mk(0, 1'b1, 1'b0, 1));
            else              exp_q.push_back(mk(0, 1'b0, 1'b0, 1));
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL halt c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_step();
        obs_t got, want;
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            halt_req = 1'b1;
            step     = (c == 10 || c == 13);
            if (c <= 7)       exp_q.push_back(mk(c, 1'b0, 1'b0, 0));
            else if (c <= 10) exp_q.push_back(mk(0, 1'b1, 1'b0, 1));
            else if (c <= 18) exp_q.push_back(mk(c - 11, 1'b0, 1'b0, 1));
            else              exp_q.push_back(mk(0, 1'b1, 1'b0, 2));
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL single_step c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
        step = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        obs_t got, want;
        int ph;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            mem_active = 1'b1;
            mem_ready  = (c < 8);
            if (c < 8)        ph = c;
            else if (c <= 12) ph = c - 8;
            else              ph = 4;
            exp_q.push_back(mk(ph, 1'b0, ph == 4, (c >= 8) ? 1 : 0));
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL wait_before_rst c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            if (c < 14) begin
                @(posedge clk); #1;
            end
        end
        #2;
        rst = 1'b1;
        exp_q.push_back('0);
        #1;
        got = sample(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL async_rst_in_wait got %s want %s", fmt(got), fmt(want));
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef SEQ_MEM_TIMEOUT_EN
    task automatic test_mem_timeout();
        obs_t got, want;
        logic to_want;
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            mem_active = (c < 25);
            mem_ready  = 1'b0;
            halt_req   = 1'b0;
            step       = (c == 25);
            if (c <= 3)       exp_q.push_back(mk(c, 1'b0, 1'b0, 0));
            else if (c <= 14) exp_q.push_back(mk(4, 1'b0, 1'b1, 0));
            else if (c <= 25) exp_q.push_back(mk(0, 1'b1, 1'b0, 0));
            else if (c <= 33) exp_q.push_back(mk(c - 26, 1'b0, 1'b0, 0));
            else              exp_q.push_back(mk(0, 1'b1, 1'b0, 1));
            to_want = (c >= 15);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL timeout c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            vectors++;
            if (mem_timeout !== to_want) begin
                miscompares++;
                $display("FAIL timeout_flag c=%0d got %b want %b", c, mem_timeout, to_want);
            end
            @(posedge clk); #1;
        end
        step = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_free_run();
        test_mem_wait();
        test_halt();
        test_single_step();
        test_reset_in_wait();
`ifdef SEQ_MEM_TIMEOUT_EN
        test_mem_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
